// File: rtl/complex_axpy_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : complex_axpy_engine                                        |
// | Description : Chunked complex AXPY, y = a + c*x (op=0) or a - c*x (op=1), |
// |               over NUM_ELEMS signed fixed-point complex elements, LANES   |
// |               elements per chunk, with a three-stage hold-able pipeline.  |
// | Config      : define COMPLEX_AXPY_SAT_EN for saturating add/sub;         |
// |               otherwise results wrap to W bits.                          |
// | Ports       : clk, reset (sync, active-high)                             |
// |               start/op/constant - request, operation, complex scalar c   |
// |               hold              - stalls every register and strobe      |
// |               rd_en/rd_addr     - chunk read request to operand memories |
// |               a_chunk/x_chunk   - operand chunks, lane i at [i*2W +: 2W] |
// |               wr_en/wr_addr/wr_data - result chunk write port           |
// |               busy/done         - operation status                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module complex_axpy_engine #(
  parameter int NUM_ELEMS = 19,
  parameter int LANES     = 8,
  parameter int W         = 32,
  parameter int FRAC      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op,
  input  logic [2*W-1:0]         constant,
  input  logic                   hold,
  output logic                   rd_en,
  output logic [31:0]            rd_addr,
  input  logic [2*W*LANES-1:0]   a_chunk,
  input  logic [2*W*LANES-1:0]   x_chunk,
  output logic                   wr_en,
  output logic [31:0]            wr_addr,
  output logic [2*W*LANES-1:0]   wr_data,
  output logic                   busy,
  output logic                   done
);

  localparam int          C_CHUNKS = (NUM_ELEMS + LANES - 1) / LANES;
  localparam int          C_LW     = 2 * W;
  localparam logic [31:0] C_LAST   = 32'(C_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [31:0]            r_rd_cnt, w_rd_cnt_nxt;
  logic                   w_accept;
  logic                   r_op;
  logic [2*W-1:0]         r_const;

  // Pipeline: stage 1 operands, stage 2 product, stage 3 result.
  logic                   r_v1, r_v2, r_v3;
  logic [31:0]            r_addr1, r_addr2, r_wr_addr;
  logic [2*W*LANES-1:0]   r_a1, r_x1, r_a2, r_p2, r_wr_data;
  logic [2*W*LANES-1:0]   w_prod, w_res;

  assign rd_addr = r_rd_cnt;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  // A valid stage-3 chunk is presented only on a non-hold cycle, so it is
  // written exactly once, on the first cycle the stall is released.
  assign wr_en   = r_v3 && !hold;

  // Reduce a W+1-bit sum/difference to W bits.
  function automatic logic [W-1:0] reduce_sum(input logic [W:0] s);
    logic unused_msb;
    unused_msb = s[W];
`ifdef COMPLEX_AXPY_SAT_EN
    if (s[W] != s[W-1]) begin
      reduce_sum = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      reduce_sum = s[W-1:0];
    end
`else
    reduce_sum = s[W-1:0];
`endif
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rd_cnt <= '0;
      r_op     <= 1'b0;
      r_const  <= '0;
    end else if (!hold) begin
      r_state  <= w_state_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
      if (w_accept) begin
        r_op    <= op;
        r_const <= constant;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_cnt_nxt = r_rd_cnt;
    w_accept     = 1'b0;
    rd_en        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !hold) begin
          w_accept     = 1'b1;
          w_rd_cnt_nxt = '0;
          w_state_nxt  = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (!hold) begin
          rd_en = 1'b1;
          if (r_rd_cnt == C_LAST) begin
            w_rd_cnt_nxt = '0;
            w_state_nxt  = DRAIN;
          end else begin
            w_rd_cnt_nxt = r_rd_cnt + 32'd1;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (wr_en && (r_wr_addr == C_LAST)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_addr1   <= '0;
      r_addr2   <= '0;
      r_wr_addr <= '0;
      r_a1      <= '0;
      r_x1      <= '0;
      r_a2      <= '0;
      r_p2      <= '0;
      r_wr_data <= '0;
    end else if (!hold) begin
      r_v1 <= rd_en;
      if (rd_en) begin
        r_addr1 <= rd_addr;
        r_a1    <= a_chunk;
        r_x1    <= x_chunk;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_addr2 <= r_addr1;
        r_a2    <= r_a1;
        r_p2    <= w_prod;
      end
      r_v3 <= r_v2;
      if (r_v2) begin
        r_wr_addr <= r_addr2;
        r_wr_data <= w_res;
      end
    end
  end

  // -------------------------------------------------------- lane datapath
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [2*W:0] w_cr, w_ci, w_xr, w_xi;
    logic signed [2*W:0] w_re_full, w_im_full, w_re_sh, w_im_sh;
    logic [W-1:0]        w_ar, w_ai, w_pr, w_pi;
    logic [W:0]          w_re_sum, w_im_sum;
    logic [31:0]         w_gidx;
    logic                w_unused_bits;

    // Stage 2 input: full-precision product, floor-shifted by FRAC.
    assign w_cr = (2*W+1)'($signed(r_const[2*W-1:W]));
    assign w_ci = (2*W+1)'($signed(r_const[W-1:0]));
    assign w_xr = (2*W+1)'($signed(r_x1[i*C_LW+W +: W]));
    assign w_xi = (2*W+1)'($signed(r_x1[i*C_LW +: W]));

    assign w_re_full = w_cr * w_xr - w_ci * w_xi;
    assign w_im_full = w_cr * w_xi + w_ci * w_xr;
    assign w_re_sh   = w_re_full >>> FRAC;
    assign w_im_sh   = w_im_full >>> FRAC;

    assign w_prod[i*C_LW +: C_LW] = {w_re_sh[W-1:0], w_im_sh[W-1:0]};
    assign w_unused_bits = ^{w_re_sh[2*W:W], w_im_sh[2*W:W]};

    // Stage 3 input: W+1-bit add/sub, reduced to W bits.
    assign w_ar = r_a2[i*C_LW+W +: W];
    assign w_ai = r_a2[i*C_LW +: W];
    assign w_pr = r_p2[i*C_LW+W +: W];
    assign w_pi = r_p2[i*C_LW +: W];

    assign w_re_sum = r_op ? ({w_ar[W-1], w_ar} - {w_pr[W-1], w_pr})
                           : ({w_ar[W-1], w_ar} + {w_pr[W-1], w_pr});
    assign w_im_sum = r_op ? ({w_ai[W-1], w_ai} - {w_pi[W-1], w_pi})
                           : ({w_ai[W-1], w_ai} + {w_pi[W-1], w_pi});

    // Lanes past the end of the vector in the final chunk are written as zero.
    assign w_gidx = r_addr2 * 32'(LANES) + 32'(i);
    assign w_res[i*C_LW +: C_LW] = (w_gidx < 32'(NUM_ELEMS))
                                 ? {reduce_sum(w_re_sum), reduce_sum(w_im_sum)}
                                 : '0;
  end : g_lane

endmodule
`default_nettype wire

// File: tb/tb_complex_axpy_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_complex_axpy_engine                                     |
// | Description : Directed self-checking bench for complex_axpy_engine,      |
// |               W=16 FRAC=8 LANES=8, NUM_ELEMS=19 plus a 16-element twin.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_complex_axpy_engine;

  localparam int W     = 16;
  localparam int FRAC  = 8;
  localparam int LANES = 8;
  localparam int DW    = 2 * W * LANES;

  logic          clk = 1'b0;
  logic          reset, start, op, hold;
  logic [2*W-1:0] constant;
  logic          rd_en, wr_en, busy, done;
  logic [31:0]   rd_addr, wr_addr;
  logic [DW-1:0] a_chunk, x_chunk, wr_data;
  logic          rd_en2, wr_en2, busy2, done2;
  logic [31:0]   unused_rd_addr2, wr_addr2;
  logic [DW-1:0] wr_data2;

  int            mem_mode;
  logic [31:0]   a_base, x_base;

  int            n_checks = 0;
  int            n_errors = 0;

  int            rd_cyc[$], rd_adr[$], wr_cyc[$], wr_adr[$], done_cyc[$];
  int            rd2_cyc[$], wr2_adr[$], done2_cyc[$];
  logic [DW-1:0] wr_dat[$], wr2_dat[$];
  logic          busy_at[32];
  logic          busy2_at[32];
  int            exp_q[$];

  always #5 clk = ~clk;

  complex_axpy_engine #(.NUM_ELEMS(19), .LANES(LANES), .W(W), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .constant(constant),
    .hold(hold), .rd_en(rd_en), .rd_addr(rd_addr), .a_chunk(a_chunk),
    .x_chunk(x_chunk), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  complex_axpy_engine #(.NUM_ELEMS(16), .LANES(LANES), .W(W), .FRAC(FRAC)) dut2 (
    .clk(clk), .reset(reset), .start(start), .op(op), .constant(constant),
    .hold(hold), .rd_en(rd_en2), .rd_addr(unused_rd_addr2), .a_chunk(a_chunk),
    .x_chunk(x_chunk), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .busy(busy2), .done(done2)
  );

  // Operand memory: uniform lanes, or a per-chunk/per-lane pattern.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_mode == 1) begin
        a_chunk[i*32 +: 32] = {16'(rd_addr * 32'd16 + 32'(i)), 16'(32'h100 + rd_addr)};
      end else begin
        a_chunk[i*32 +: 32] = a_base;
      end
      x_chunk[i*32 +: 32] = x_base;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_list(input string tag, input int act[$], input int exp[$]);
    chk({tag, "_count"}, DW'(act.size()), DW'(exp.size()));
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), DW'(act[i]), DW'(exp[i]));
  endtask

  // First n lanes hold v, remaining lanes zero.
  function automatic logic [DW-1:0] fill(input logic [31:0] v, input int n);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  // Expected chunk for pattern memory with c = 0 (result equals a), 19 elements.
  function automatic logic [DW-1:0] pattern_chunk(input int k);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      if (k * LANES + i < 19) r[i*32 +: 32] = {16'(k * 16 + i), 16'(256 + k)};
    return r;
  endfunction

  // One operation: start at cycle 0; op/constant are corrupted afterwards.
  task automatic run_op(input logic op_v, input logic [31:0] c_v, input int hold_from,
                        input int hold_len, input int rst_at, input int start2_at,
                        input int ncyc);
    rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete();
    done_cyc.delete(); wr_dat.delete(); rd2_cyc.delete(); wr2_adr.delete();
    wr2_dat.delete(); done2_cyc.delete();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      start    = (cyc == 0) || (cyc == start2_at);
      op       = (cyc == 0) ? op_v : ~op_v;
      constant = (cyc == 0) ? c_v : ~c_v;
      hold     = (cyc >= hold_from) && (cyc < hold_from + hold_len);
      reset    = (cyc == rst_at);
      #1;
      if (rd_en)  begin rd_cyc.push_back(cyc); rd_adr.push_back(int'(rd_addr)); end
      if (wr_en)  begin wr_cyc.push_back(cyc); wr_adr.push_back(int'(wr_addr)); wr_dat.push_back(wr_data); end
      if (done)   done_cyc.push_back(cyc);
      if (rd_en2) rd2_cyc.push_back(cyc);
      if (wr_en2) begin wr2_adr.push_back(int'(wr_addr2)); wr2_dat.push_back(wr_data2); end
      if (done2)  done2_cyc.push_back(cyc);
      busy_at[cyc]  = busy;
      busy2_at[cyc] = busy2;
    end
    @(negedge clk);
    start = 1'b0; hold = 1'b0; reset = 1'b0;
  endtask

  logic [31:0] v_a;
  logic [31:0] v_sat;
  int          late;

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; hold = 1'b0; constant = '0;
    mem_mode = 0; a_base = '0; x_base = '0;
    repeat (3) @(negedge clk);
    #1;
    // Reset state
    chk("rst_rd_en",   DW'(rd_en),   DW'(0));
    chk("rst_wr_en",   DW'(wr_en),   DW'(0));
    chk("rst_busy",    DW'(busy),    DW'(0));
    chk("rst_done",    DW'(done),    DW'(0));
    chk("rst_rd_addr", DW'(rd_addr), DW'(0));
    chk("rst_wr_addr", DW'(wr_addr), DW'(0));
    chk("rst_wr_data", wr_data,      '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // a + c*x: c=(1.0,0), x=(2.0,1.0), a=(1.0,1.0) -> (3.0, 2.0)
    a_base = 32'h0100_0100; x_base = 32'h0200_0100; mem_mode = 0;
    run_op(1'b0, 32'h0100_0000, -1, 0, -1, -1, 12);
    v_a = 32'h0300_0200;
    exp_q = '{1, 2, 3};    check_list("A_rd_cyc", rd_cyc, exp_q);
    exp_q = '{0, 1, 2};    check_list("A_rd_addr", rd_adr, exp_q);
    exp_q = '{4, 5, 6};    check_list("A_wr_cyc", wr_cyc, exp_q);
    exp_q = '{0, 1, 2};    check_list("A_wr_addr", wr_adr, exp_q);
    exp_q = '{7};          check_list("A_done_cyc", done_cyc, exp_q);
    if (wr_dat.size() == 3) begin
      chk("A_chunk0", wr_dat[0], fill(v_a, 8));
      chk("A_chunk1", wr_dat[1], fill(v_a, 8));
      chk("A_chunk2_pad", wr_dat[2], fill(v_a, 3));
    end
    chk("A_busy_c0", DW'(busy_at[0]), DW'(0));
    chk("A_busy_c1", DW'(busy_at[1]), DW'(1));
    chk("A_busy_c6", DW'(busy_at[6]), DW'(1));
    chk("A_busy_c8", DW'(busy_at[8]), DW'(0));
    // 16-element twin: exact multiple, no padded lanes
    exp_q = '{1, 2};       check_list("A2_rd_cyc", rd2_cyc, exp_q);
    exp_q = '{0, 1};       check_list("A2_wr_addr", wr2_adr, exp_q);
    exp_q = '{6};          check_list("A2_done_cyc", done2_cyc, exp_q);
    chk("A2_busy_c1", DW'(busy2_at[1]), DW'(1));
    if (wr2_dat.size() == 2) chk("A2_chunk1_full", wr2_dat[1], fill(v_a, 8));

    // a - c*x: c=(0,1.0), x=(1.0,0), a=0 -> (0, -1.0)
    a_base = 32'h0000_0000; x_base = 32'h0100_0000;
    run_op(1'b1, 32'h0000_0100, -1, 0, -1, -1, 12);
    v_a = 32'h0000_FF00;
    exp_q = '{0, 1, 2};    check_list("B_wr_addr", wr_adr, exp_q);
    if (wr_dat.size() == 3) begin
      chk("B_chunk0", wr_dat[0], fill(v_a, 8));
      chk("B_chunk2_pad", wr_dat[2], fill(v_a, 3));
    end

    // Positive overflow: 0x7F00 + 0x0200
`ifdef COMPLEX_AXPY_SAT_EN
    v_sat = 32'h7FFF_0000;
`else
    v_sat = 32'h8100_0000;
`endif
    a_base = 32'h7F00_0000; x_base = 32'h0200_0000;
    run_op(1'b0, 32'h0100_0000, -1, 0, -1, -1, 12);
    if (wr_dat.size() == 3) chk("C_overflow_pos", wr_dat[0], fill(v_sat, 8));
    else chk("C_wr_count", DW'(wr_dat.size()), DW'(3));

    // Negative overflow: 0x8100 - 0x0200
`ifdef COMPLEX_AXPY_SAT_EN
    v_sat = 32'h8000_0000;
`else
    v_sat = 32'h7F00_0000;
`endif
    a_base = 32'h8100_0000;
    run_op(1'b1, 32'h0100_0000, -1, 0, -1, -1, 12);
    if (wr_dat.size() == 3) chk("C_overflow_neg", wr_dat[0], fill(v_sat, 8));
    else chk("C_wr_count_neg", DW'(wr_dat.size()), DW'(3));

    // Two-cycle hold mid-RUN; distinct data per chunk, c=0 so result = a
    mem_mode = 1; x_base = 32'h1234_5678;
    run_op(1'b0, 32'h0000_0000, 2, 2, -1, -1, 14);
    exp_q = '{1, 4, 5};    check_list("D_rd_cyc", rd_cyc, exp_q);
    exp_q = '{6, 7, 8};    check_list("D_wr_cyc", wr_cyc, exp_q);
    exp_q = '{0, 1, 2};    check_list("D_wr_addr", wr_adr, exp_q);
    exp_q = '{9};          check_list("D_done_cyc", done_cyc, exp_q);
    for (int k = 0; k < 3 && k < wr_dat.size(); k++)
      chk($sformatf("D_chunk%0d", k), wr_dat[k], pattern_chunk(k));

    // start while busy ignored; op/constant stay latched
    mem_mode = 0; a_base = 32'h0100_0100; x_base = 32'h0200_0100;
    v_a = 32'h0300_0200;
    run_op(1'b0, 32'h0100_0000, -1, 0, -1, 3, 14);
    exp_q = '{0, 1, 2};    check_list("E_rd_addr", rd_adr, exp_q);
    if (wr_dat.size() == 3) chk("E_latched_chunk1", wr_dat[1], fill(v_a, 8));

    // start in the DONE cycle ignored
    run_op(1'b0, 32'h0100_0000, -1, 0, -1, 7, 18);
    exp_q = '{1, 2, 3};    check_list("F_rd_cyc", rd_cyc, exp_q);

    // start in the IDLE cycle after DONE accepted
    run_op(1'b0, 32'h0100_0000, -1, 0, -1, 8, 18);
    exp_q = '{1, 2, 3, 9, 10, 11}; check_list("G_rd_cyc", rd_cyc, exp_q);
    exp_q = '{7, 15};      check_list("G_done_cyc", done_cyc, exp_q);

    // reset in DRAIN, together with hold and start, aborts the operation
    run_op(1'b0, 32'h0100_0000, 5, 1, 5, 5, 14);
    late = 0;
    foreach (wr_cyc[i]) if (wr_cyc[i] > 5) late++;
    foreach (rd_cyc[i]) if (rd_cyc[i] > 5) late++;
    chk("H_no_activity_after_reset", DW'(late), DW'(0));
    chk("H_no_done", DW'(done_cyc.size()), DW'(0));
    chk("H_busy_after_reset", DW'(busy_at[6]), DW'(0));

    // next operation after the abort completes normally
    run_op(1'b0, 32'h0100_0000, -1, 0, -1, -1, 12);
    exp_q = '{4, 5, 6};    check_list("H2_wr_cyc", wr_cyc, exp_q);
    exp_q = '{7};          check_list("H2_done_cyc", done_cyc, exp_q);
    if (wr_dat.size() == 3) chk("H2_chunk2_pad", wr_dat[2], fill(v_a, 3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
